// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_mp_pkg;

   localparam int unsigned DefWidth = 64;
   localparam int unsigned DefDepth = 32;
   // Widest pending vector the popcount helper accepts; callers zero-extend.
   localparam int unsigned MaxDepth = 1024;

   function automatic int unsigned popcount(input logic [MaxDepth-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MaxDepth; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: per-register busy bits, read-port busy flags and a
// registered count of pending registers.
module regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       wr_en0_i,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr0_i,
   input  logic                       wr_en1_i,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr1_i,
   input  logic                       alloc_en_i,
   input  logic [$clog2(DEPTH)-1:0]   alloc_addr_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr0_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr1_i,
   output logic                       rd_busy0_o,
   output logic                       rd_busy1_o,
   output logic [$clog2(DEPTH):0]     busy_count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DEPTH-1:0]    pend_q, pend_d;
   logic [AW:0]         busy_count_q, busy_count_d;
   logic [MaxDepth-1:0] pend_ext;

   // Alloc is applied after the clears so a new producer wins over a retiring write.
   always_comb begin
      pend_d = pend_q;
      if (wr_en0_i) pend_d[wr_addr0_i] = 1'b0;
      if (wr_en1_i) pend_d[wr_addr1_i] = 1'b0;
      if (alloc_en_i) pend_d[alloc_addr_i] = 1'b1;
      pend_ext = '0;
      pend_ext[DEPTH-1:0] = pend_d;
      busy_count_d = (AW+1)'(popcount(pend_ext));
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         pend_q       <= '0;
         busy_count_q <= '0;
      end else begin
         pend_q       <= pend_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign rd_busy0_o = pend_q[rd_addr0_i] &
                       ~((wr_en0_i & (wr_addr0_i == rd_addr0_i)) |
                         (wr_en1_i & (wr_addr1_i == rd_addr0_i)));
   assign rd_busy1_o = pend_q[rd_addr1_i] &
                       ~((wr_en0_i & (wr_addr0_i == rd_addr1_i)) |
                         (wr_en1_i & (wr_addr1_i == rd_addr1_i)));
   assign busy_count_o = busy_count_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-read, two-write register file with write-through bypass and a pending
// scoreboard for outstanding producers.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned DEPTH    = DefDepth,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr0_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr1_i,
   output logic [WIDTH-1:0]           rd_data0_o,
   output logic [WIDTH-1:0]           rd_data1_o,
   output logic                       rd_busy0_o,
   output logic                       rd_busy1_o,
   input  logic                       wr_en0_i,
   input  logic                       wr_en1_i,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr0_i,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr1_i,
   input  logic [WIDTH-1:0]           wr_data0_i,
   input  logic [WIDTH-1:0]           wr_data1_i,
   input  logic                       alloc_en_i,
   input  logic [$clog2(DEPTH)-1:0]   alloc_addr_i,
   output logic [$clog2(DEPTH):0]     busy_count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam bit ZeroEn = (ZERO_REG != 0);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             we0, we1, alloc;

   // Register 0 is hardwired when ZeroEn: its writes and allocs vanish here.
   assign we0   = wr_en0_i & ~(ZeroEn & (wr_addr0_i == '0));
   assign we1   = wr_en1_i & ~(ZeroEn & (wr_addr1_i == '0));
   assign alloc = alloc_en_i & ~(ZeroEn & (alloc_addr_i == '0));

   // Port 1 is the later assignment, so it wins a same-address collision.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (we0) mem_q[wr_addr0_i] <= wr_data0_i;
         if (we1) mem_q[wr_addr1_i] <= wr_data1_i;
      end
   end

   always_comb begin
      rd_data0_o = mem_q[rd_addr0_i];
      if (we1 && (wr_addr1_i == rd_addr0_i)) rd_data0_o = wr_data1_i;
      else if (we0 && (wr_addr0_i == rd_addr0_i)) rd_data0_o = wr_data0_i;
      if (reset_i || (ZeroEn && (rd_addr0_i == '0))) rd_data0_o = '0;

      rd_data1_o = mem_q[rd_addr1_i];
      if (we1 && (wr_addr1_i == rd_addr1_i)) rd_data1_o = wr_data1_i;
      else if (we0 && (wr_addr0_i == rd_addr1_i)) rd_data1_o = wr_data0_i;
      if (reset_i || (ZeroEn && (rd_addr1_i == '0))) rd_data1_o = '0;
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH)
   ) u_scoreboard (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .wr_en0_i     (we0),
      .wr_addr0_i   (wr_addr0_i),
      .wr_en1_i     (we1),
      .wr_addr1_i   (wr_addr1_i),
      .alloc_en_i   (alloc),
      .alloc_addr_i (alloc_addr_i),
      .rd_addr0_i   (rd_addr0_i),
      .rd_addr1_i   (rd_addr1_i),
      .rd_busy0_o   (rd_busy0_o),
      .rd_busy1_o   (rd_busy1_o),
      .busy_count_o (busy_count_o)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, randomized traffic against an
// array-based reference, and an asynchronous reset sequence.
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rd_addr0 = '0, rd_addr1 = '0;
   logic [63:0] rd_data0, rd_data1;
   logic        rd_busy0, rd_busy1;
   logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
   logic [4:0]  wr_addr0 = '0, wr_addr1 = '0;
   logic [63:0] wr_data0 = '0, wr_data1 = '0;
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_addr = '0;
   logic [5:0]  busy_count;

   int total = 0;
   int bad = 0;

   logic [63:0] m_mem [32];
   bit          m_pend [32];

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [63:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [63:0] wd1;
      logic        al;
      logic [4:0]  aa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] xd0;
      logic [63:0] xd1;
      logic        xb0;
      logic        xb1;
      logic [5:0]  xc;
   } vec_t;

   vec_t tbl [15];

   regfile_mp dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .rd_addr0_i   (rd_addr0),
      .rd_addr1_i   (rd_addr1),
      .rd_data0_o   (rd_data0),
      .rd_data1_o   (rd_data1),
      .rd_busy0_o   (rd_busy0),
      .rd_busy1_o   (rd_busy1),
      .wr_en0_i     (wr_en0),
      .wr_en1_i     (wr_en1),
      .wr_addr0_i   (wr_addr0),
      .wr_addr1_i   (wr_addr1),
      .wr_data0_i   (wr_data0),
      .wr_data1_i   (wr_data1),
      .alloc_en_i   (alloc_en),
      .alloc_addr_i (alloc_addr),
      .busy_count_o (busy_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int we0, input int wa0, input logic [63:0] wd0,
                               input int we1, input int wa1, input logic [63:0] wd1,
                               input int al, input int aa, input int ra0, input int ra1,
                               input logic [63:0] xd0, input logic [63:0] xd1,
                               input int xb0, input int xb1, input int xc);
      vec_t v;
      v.we0 = (we0 != 0); v.wa0 = 5'(wa0); v.wd0 = wd0;
      v.we1 = (we1 != 0); v.wa1 = 5'(wa1); v.wd1 = wd1;
      v.al  = (al != 0);  v.aa  = 5'(aa);
      v.ra0 = 5'(ra0);    v.ra1 = 5'(ra1);
      v.xd0 = xd0; v.xd1 = xd1;
      v.xb0 = (xb0 != 0); v.xb1 = (xb1 != 0); v.xc = 6'(xc);
      return v;
   endfunction

   task automatic drive(input logic we0, input logic [4:0] wa0, input logic [63:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [63:0] wd1,
                        input logic al, input logic [4:0] aa,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en0 = we0; wr_addr0 = wa0; wr_data0 = wd0;
      wr_en1 = we1; wr_addr1 = wa1; wr_data1 = wd1;
      alloc_en = al; alloc_addr = aa;
      rd_addr0 = ra0; rd_addr1 = ra1;
   endtask

   // Reference: read value and busy seen by a reader this cycle.
   function automatic logic [63:0] m_rd(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (wr_en1 && wr_addr1 == a) return wr_data1;
      if (wr_en0 && wr_addr0 == a) return wr_data0;
      return m_mem[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if ((wr_en1 && wr_addr1 == a) || (wr_en0 && wr_addr0 == a)) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
      return n;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic clock_edge();
      @(posedge clock);
      if (wr_en0 && wr_addr0 != 5'd0) begin
         m_mem[wr_addr0] = wr_data0;
         m_pend[wr_addr0] = 1'b0;
      end
      if (wr_en1 && wr_addr1 != 5'd0) begin
         m_mem[wr_addr1] = wr_data1;
         m_pend[wr_addr1] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
      #1;
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      m_clear();
      // Reset held: a write and alloc with bypass address must all read as zero.
      #3;
      drive(1'b1, 5'd5, 64'hABCD, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd5, 5'd31);
      #1;
      chk("rst_d0", rd_data0, 64'd0);
      chk("rst_d1", rd_data1, 64'd0);
      chk("rst_b0", 64'(rd_busy0), 64'd0);
      chk("rst_cnt", 64'(busy_count), 64'd0);
      @(posedge clock);
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd31);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      tbl[0]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 5, 31,
                   64'h0, 64'h0, 0, 0, 0);
      tbl[1]  = mk(1, 3, 64'hDEAD_BEEF,  0, 0, 64'h0,  0, 0, 3, 3,
                   64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 0, 0);
      tbl[2]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 3, 5,
                   64'hDEAD_BEEF, 64'h0, 0, 0, 0);
      tbl[3]  = mk(1, 7, 64'h11,         1, 7, 64'h22, 0, 0, 7, 3,
                   64'h22, 64'hDEAD_BEEF, 0, 0, 0);
      tbl[4]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 7, 7,
                   64'h22, 64'h22, 0, 0, 0);
      tbl[5]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  1, 9, 9, 5,
                   64'h0, 64'h0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 9, 9,
                   64'h0, 64'h0, 1, 1, 1);
      tbl[7]  = mk(1, 9, 64'h99,         0, 0, 64'h0,  0, 0, 9, 5,
                   64'h99, 64'h0, 0, 0, 1);
      tbl[8]  = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 9, 9,
                   64'h99, 64'h99, 0, 0, 0);
      tbl[9]  = mk(0, 0, 64'h0,          1, 9, 64'hAB, 1, 9, 9, 3,
                   64'hAB, 64'hDEAD_BEEF, 0, 0, 0);
      tbl[10] = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 9, 9,
                   64'hAB, 64'hAB, 1, 1, 1);
      tbl[11] = mk(1, 0, 64'hFF,         1, 0, 64'hFF, 1, 0, 0, 0,
                   64'h0, 64'h0, 0, 0, 1);
      tbl[12] = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 0, 9,
                   64'h0, 64'hAB, 0, 1, 1);
      tbl[13] = mk(0, 0, 64'h0,          0, 0, 64'h0,  1, 9, 9, 0,
                   64'hAB, 64'h0, 1, 0, 1);
      tbl[14] = mk(0, 0, 64'h0,          0, 0, 64'h0,  0, 0, 9, 7,
                   64'hAB, 64'h22, 1, 0, 1);

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].we0, tbl[i].wa0, tbl[i].wd0, tbl[i].we1, tbl[i].wa1, tbl[i].wd1,
               tbl[i].al, tbl[i].aa, tbl[i].ra0, tbl[i].ra1);
         #2;
         chk($sformatf("vec%0d_d0", i), rd_data0, tbl[i].xd0);
         chk($sformatf("vec%0d_d1", i), rd_data1, tbl[i].xd1);
         chk($sformatf("vec%0d_b0", i), 64'(rd_busy0), 64'(tbl[i].xb0));
         chk($sformatf("vec%0d_b1", i), 64'(rd_busy1), 64'(tbl[i].xb1));
         chk($sformatf("vec%0d_cnt", i), 64'(busy_count), 64'(tbl[i].xc));
         clock_edge();
      end

      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
               1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
               1'($urandom_range(0, 1)), rand_addr(), rand_addr(), rand_addr());
         #2;
         chk("rnd_d0", rd_data0, m_rd(rd_addr0));
         chk("rnd_d1", rd_data1, m_rd(rd_addr1));
         chk("rnd_b0", 64'(rd_busy0), 64'(m_busy(rd_addr0)));
         chk("rnd_b1", 64'(rd_busy1), 64'(m_busy(rd_addr1)));
         chk("rnd_cnt", 64'(busy_count), 64'(m_count()));
         clock_edge();
      end

      // r4 both written and pending, then reset lands mid-cycle.
      drive(1'b1, 5'd4, 64'h4444, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd4, 5'd4);
      clock_edge();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
      #2;
      chk("pre_rst_d0", rd_data0, 64'h4444);
      chk("pre_rst_b0", 64'(rd_busy0), 64'd1);
      chk("pre_rst_cnt", 64'(busy_count), 64'(m_count()));
      #1;
      reset = 1'b1;
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'h5555, 1'b1, 5'd4, 5'd4, 5'd4);
      #1;
      chk("async_rst_d0", rd_data0, 64'd0);
      chk("async_rst_d1", rd_data1, 64'd0);
      chk("async_rst_b0", 64'(rd_busy0), 64'd0);
      chk("async_rst_cnt", 64'(busy_count), 64'd0);
      @(posedge clock);
      #1;
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
      #2;
      reset = 1'b0;
      m_clear();
      #1;
      chk("post_rst_d0", rd_data0, 64'd0);
      chk("post_rst_b0", 64'(rd_busy0), 64'd0);
      chk("post_rst_cnt", 64'(busy_count), 64'd0);
      clock_edge();
      drive(1'b1, 5'd4, 64'h77, 1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 5'd4, 5'd6);
      #2;
      chk("rel_wr_d0", rd_data0, 64'h77);
      clock_edge();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd6);
      #2;
      chk("rel_rd_d0", rd_data0, m_rd(5'd4));
      chk("rel_b1", 64'(rd_busy1), 64'(m_busy(5'd6)));
      chk("rel_cnt", 64'(busy_count), 64'(m_count()));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 64: bits per register.
REQ-002 Parameter DEPTH, default 32: register count; power of two, >= 2; address width AW = clog2(DEPTH), derived, not overridable.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rd_addr0, rd_addr1  in  AW  read-port register numbers.
REQ-007 rd_data0, rd_data1  out  WIDTH  read-port values.
REQ-008 rd_busy0, rd_busy1  out  1  addressed register has an outstanding producer.
REQ-009 wr_en0, wr_en1  in  1  write-port enables.
REQ-010 wr_addr0, wr_addr1  in  AW  write-port register numbers.
REQ-011 wr_data0, wr_data1  in  WIDTH  write-port data.
REQ-012 alloc_en  in  1  mark a register as pending (producer issued).
REQ-013 alloc_addr  in  AW  register to mark pending.
REQ-014 busy_count  out  AW+1  number of registers currently pending.

Function
REQ-015 Storage: DEPTH x WIDTH array plus DEPTH-bit pending vector.
REQ-016 Writes: on rising edge, each enabled write port updates its register.
REQ-017 Same-address dual write: port 1 wins; port 0 data discarded.
REQ-018 Reads: combinational, zero latency; rd_dataN = array[rd_addrN] unless bypassed.
REQ-019 Bypass: if any enabled write port targets rd_addrN in the same cycle, rd_dataN = that write data (port 1 priority), i.e. write-through.
REQ-020 Pending clear: an enabled write to register r clears pending[r] at the edge.
REQ-021 Pending set: alloc_en sets pending[alloc_addr] at the edge.
REQ-022 Alloc and write to same register in same cycle: pending ends set (new producer wins); data still written.
REQ-023 rd_busyN = pending[rd_addrN] AND NOT (enabled write to rd_addrN this cycle).
REQ-024 busy_count = population count of pending vector, registered; reflects post-edge state one cycle after the causing edge is NOT allowed: it updates on the same edge as pending.
REQ-025 Alloc to an already-pending register: no change, no error.
REQ-026 ZERO_REG=1: writes/allocs to address 0 are ignored; rd_data=0, rd_busy=0 for address 0, bypass suppressed.
REQ-027 Address range is exactly DEPTH; no out-of-range case exists.

Reset
REQ-028 reset asserted: all registers = 0, pending = 0, busy_count = 0, immediately and independent of clock.
REQ-029 While reset asserted: writes and allocs ignored; rd_data reflects cleared array (bypass still applies combinationally is NOT allowed: rd_data = 0, rd_busy = 0).
REQ-030 Reset deasserted mid-operation: first rising edge after release behaves as normal cycle.

Structure
REQ-031 Shared package holds default WIDTH/DEPTH constants and the popcount function.
REQ-032 One sub-module natural: regfile_scoreboard (pending vector, alloc/clear, busy flags, busy_count); data array and bypass stay in regfile_mp.

Verification
REQ-033 Reset then read r5, r31 -> rd_data0/1 = 0, rd_busy = 0, busy_count = 0.
REQ-034 Write r3=0xDEAD_BEEF via port 0 while reading r3 same cycle -> rd_data0 = 0xDEAD_BEEF before and after edge.
REQ-035 Both ports write r7 (0x11, 0x22) -> next cycle r7 reads 0x22.
REQ-036 alloc r9; next cycle rd_busy=1, busy_count=1; write r9 -> rd_busy=0 in write cycle, busy_count=0 after edge; alloc+write r9 same cycle -> busy stays 1.
REQ-037 Write 0xFF to r0, alloc r0 (ZERO_REG=1) -> r0 reads 0, never busy, busy_count unchanged.
REQ-038 Assert reset asynchronously mid-cycle with r4 pending and written -> outputs clear before next edge; r4 reads 0 after release.
